// File: rtl/y86_pkg.sv
// Shared Y86 memory-stage definitions: icodes, status codes, FSM states.
package y86_pkg;

    localparam logic [3:0] HALT  = 4'h0;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] RMMOV = 4'h4;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] CALL  = 4'h8;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] PUSH  = 4'hA;
    localparam logic [3:0] POP   = 4'hB;

    localparam logic [1:0] STAT_AOK  = 2'd0;
    localparam logic [1:0] STAT_ADR  = 2'd1;
    localparam logic [1:0] STAT_DMEM = 2'd2;
    localparam logic [1:0] STAT_TMO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of the memory-stage access from icode and operands.
module mem_op_decode
    import y86_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int MEM_LAST = 4095
) (
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] val_e,
    input  logic [ADDR_W-1:0] val_a,
    input  logic [ADDR_W-1:0] val_p,
    output logic              access,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] wdata,
    output logic              addr_ok
);

    always_comb begin
        access = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        unique case (icode)
            RMMOV, PUSH: begin
                access = 1'b1;
                we     = 1'b1;
                addr   = val_e;
                wdata  = val_a;
            end
            CALL: begin
                access = 1'b1;
                we     = 1'b1;
                addr   = val_e;
                wdata  = val_p;
            end
            MRMOV: begin
                access = 1'b1;
                addr   = val_e;
            end
            POP, RET: begin
                access = 1'b1;
                addr   = val_a;
            end
            default: ;
        endcase
    end

    // Unsigned compare: negative addresses are simply huge and out of range.
    assign addr_ok = (addr <= ADDR_W'(MEM_LAST));

endmodule

// File: rtl/mem_stage_requester.sv
// SEQ memory stage: issues one req/ack data-memory access per start pulse.
module mem_stage_requester
    import y86_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int MEM_LAST = 4095,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] val_e,
    input  logic [ADDR_W-1:0] val_a,
    input  logic [ADDR_W-1:0] val_p,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] val_m,
    output logic [1:0]        stat
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              dec_access;
    logic              dec_we;
    logic [ADDR_W-1:0] dec_addr;
    logic [ADDR_W-1:0] dec_wdata;
    logic              dec_ok;

    mem_op_decode #(
        .ADDR_W  (ADDR_W),
        .MEM_LAST(MEM_LAST)
    ) u_dec (
        .icode  (icode),
        .val_e  (val_e),
        .val_a  (val_a),
        .val_p  (val_p),
        .access (dec_access),
        .we     (dec_we),
        .addr   (dec_addr),
        .wdata  (dec_wdata),
        .addr_ok(dec_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            val_m     <= '0;
            stat      <= STAT_AOK;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!dec_access) begin
                            state <= RESP;
                            done  <= 1'b1;
                            stat  <= STAT_AOK;
                        end else if (!dec_ok) begin
                            state <= RESP;
                            done  <= 1'b1;
                            stat  <= STAT_ADR;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= dec_we;
                            mem_addr  <= dec_addr;
                            mem_wdata <= dec_wdata;
                            cnt       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        stat    <= mem_err ? STAT_DMEM : STAT_AOK;
                        if (!mem_we)
                            val_m <= mem_rdata;
                    end else begin
                        cnt <= cnt + CW'(1);
                        // Final unacked cycle: give up on the responder.
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            stat    <= STAT_TMO;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_requester.sv
// Directed self-checking bench for mem_stage_requester.
module tb_mem_stage_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_p;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        busy;
    logic        done;
    logic [63:0] val_m;
    logic [1:0]  stat;

    int checks = 0;
    int errors = 0;

    mem_stage_requester dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .icode    (icode),
        .val_e    (val_e),
        .val_a    (val_a),
        .val_p    (val_p),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_err  (mem_err),
        .busy     (busy),
        .done     (done),
        .val_m    (val_m),
        .stat     (stat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p);
        start = 1'b1;
        icode = ic;
        val_e = e;
        val_a = a;
        val_p = p;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        icode = 4'h0;
        val_e = '0;
        val_a = '0;
        val_p = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mem_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valm", val_m, 64'd0);
        chk("rst_stat", {62'd0, stat}, 64'd0);
        tick();

        // mrmovq, ack in third req cycle
        issue(4'h5, 64'd100, 64'd0, 64'd0);
        chk("mr_req1", {63'd0, mem_req}, 64'd1);
        chk("mr_we", {63'd0, mem_we}, 64'd0);
        chk("mr_addr", mem_addr, 64'd100);
        chk("mr_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("mr_req2", {63'd0, mem_req}, 64'd1);
        chk("mr_done2", {63'd0, done}, 64'd0);
        tick();
        chk("mr_req3", {63'd0, mem_req}, 64'd1);
        mem_ack = 1'b1;
        mem_rdata = 64'h1234;
        tick();
        mem_ack = 1'b0;
        chk("mr_req_drop", {63'd0, mem_req}, 64'd0);
        chk("mr_done", {63'd0, done}, 64'd1);
        chk("mr_valm", val_m, 64'h1234);
        chk("mr_stat", {62'd0, stat}, 64'd0);
        tick();
        chk("mr_done_pulse", {63'd0, done}, 64'd0);

        // pushq at top legal address, immediate ack
        issue(4'hA, 64'd4095, -64'sd7, 64'd0);
        chk("push_req", {63'd0, mem_req}, 64'd1);
        chk("push_we", {63'd0, mem_we}, 64'd1);
        chk("push_addr", mem_addr, 64'd4095);
        chk("push_wdata", mem_wdata, 64'hFFFF_FFFF_FFFF_FFF9);
        mem_ack = 1'b1;
        mem_rdata = 64'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("push_done", {63'd0, done}, 64'd1);
        chk("push_stat", {62'd0, stat}, 64'd0);
        chk("push_valm_held", val_m, 64'h1234);
        tick();

        // rmmovq just past the end
        issue(4'h4, 64'd4096, 64'd3, 64'd0);
        chk("adr_req", {63'd0, mem_req}, 64'd0);
        chk("adr_done", {63'd0, done}, 64'd1);
        chk("adr_stat", {62'd0, stat}, 64'd1);
        chk("adr_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("adr_done_pulse", {63'd0, done}, 64'd0);
        chk("adr_busy_clr", {63'd0, busy}, 64'd0);
        tick();
        issue(4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0);
        chk("adr2_req", {63'd0, mem_req}, 64'd0);
        chk("adr2_done", {63'd0, done}, 64'd1);
        chk("adr2_stat", {62'd0, stat}, 64'd1);
        tick();

        // call, responder never acks
        issue(4'h8, 64'd50, 64'd0, 64'h20);
        chk("tmo_we", {63'd0, mem_we}, 64'd1);
        chk("tmo_addr", mem_addr, 64'd50);
        chk("tmo_wdata", mem_wdata, 64'h20);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tmo_req%0d", i), {63'd0, mem_req}, 64'd1);
            tick();
        end
        chk("tmo_req_drop", {63'd0, mem_req}, 64'd0);
        chk("tmo_done", {63'd0, done}, 64'd1);
        chk("tmo_stat", {62'd0, stat}, 64'd3);
        chk("tmo_busy", {63'd0, busy}, 64'd0);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD;
        tick();
        mem_ack = 1'b0;
        chk("late_done", {63'd0, done}, 64'd0);
        chk("late_busy", {63'd0, busy}, 64'd0);
        chk("late_stat", {62'd0, stat}, 64'd3);
        chk("late_valm", val_m, 64'h1234);
        tick();

        // ret with responder error; address comes from val_a
        issue(4'h9, 64'd999999, 64'd10, 64'd0);
        chk("ret_addr", mem_addr, 64'd10);
        chk("ret_we", {63'd0, mem_we}, 64'd0);
        mem_ack = 1'b1;
        mem_err = 1'b1;
        mem_rdata = 64'hABCD;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        chk("ret_done", {63'd0, done}, 64'd1);
        chk("ret_stat", {62'd0, stat}, 64'd2);
        chk("ret_valm", val_m, 64'hABCD);
        tick();
        issue(4'h1, 64'd5, 64'd6, 64'd7);
        chk("nop_req", {63'd0, mem_req}, 64'd0);
        chk("nop_done", {63'd0, done}, 64'd1);
        chk("nop_stat", {62'd0, stat}, 64'd0);
        chk("nop_valm", val_m, 64'hABCD);
        tick();

        // busy start ignored, then reset mid-REQ
        issue(4'h5, 64'd200, 64'd0, 64'd0);
        issue(4'h4, 64'd300, 64'd1, 64'd0);
        chk("busy_addr", mem_addr, 64'd200);
        chk("busy_we", {63'd0, mem_we}, 64'd0);
        chk("busy_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("mid_rst_done2", {63'd0, done}, 64'd0);
        issue(4'h5, 64'd7, 64'd0, 64'd0);
        chk("fresh_req", {63'd0, mem_req}, 64'd1);
        chk("fresh_addr", mem_addr, 64'd7);
        mem_ack = 1'b1;
        mem_rdata = 64'h55;
        tick();
        mem_ack = 1'b0;
        chk("fresh_done", {63'd0, done}, 64'd1);
        chk("fresh_valm", val_m, 64'h55);
        chk("fresh_stat", {62'd0, stat}, 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_requester.md
Name: mem_stage_requester

Overview:
- Initiator side of the SEQ data-memory interface. It decodes the memory-stage operation from icode, valE, valA and valP, then issues one read or write request to a variable-latency data memory using a req/ack handshake.
- It returns valM and a memory status to the write-back and PC-update logic.
- It sits between execute and write-back, in front of the data-memory responder.

Parameters:
- ADDR_W, 64, address and data width.
- MEM_LAST, 4095, highest legal word address (inclusive).
- TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: the operands below are valid and an operation begins.
- icode  in  4  Y86 instruction code.
- val_e  in  64  ALU result.
- val_a  in  64  register A value.
- val_p  in  64  next-PC value.
- mem_req  out  1  request valid to data memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  64  word address.
- mem_wdata  out  64  write data.
- mem_ack  in  1  responder completion, sampled only while mem_req is high.
- mem_rdata  in  64  read data, valid in the mem_ack cycle.
- mem_err  in  1  responder error, valid in the mem_ack cycle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid.
- val_m  out  64  read result.
- stat  out  2  status: 0 AOK, 1 ADR (address out of range), 2 DMEM (responder error), 3 TMO (timeout).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, val_m=0, stat=0, timeout counter=0.
- Decode, captured on the start edge:
  - icode 4 (rmmovq): write, addr=val_e, data=val_a.
  - icode 5 (mrmovq): read, addr=val_e.
  - icode 8 (call): write, addr=val_e, data=val_p.
  - icode 0xA (pushq): write, addr=val_e, data=val_a.
  - icode 0xB (popq): read, addr=val_a.
  - icode 9 (ret): read, addr=val_a.
  - All other icodes: no access.
- Range check: compare the unsigned address against MEM_LAST.
- States: IDLE, REQ, RESP.
- IDLE:
  - start=1 with no-access icode → RESP; done pulses at the next edge with stat=AOK; val_m is unchanged.
  - start=1 with out-of-range address → RESP; stat=ADR; no mem_req is ever asserted.
  - start=1 with a legal access → REQ; mem_req, mem_we, mem_addr and mem_wdata are registered at the same edge. mem_req is therefore high in cycle t+1 for a start in cycle t.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until an ack is sampled.
  - mem_ack=1 → at that edge: mem_req=0; val_m=mem_rdata on a read (val_m is held on a write); stat=DMEM if mem_err else AOK; done=1 in the following cycle; state → IDLE.
  - Ack in the first req cycle is legal. Minimum latency start→done is 2 cycles.
  - The counter increments each REQ cycle without ack. When it reaches TIMEOUT: drop mem_req, stat=TMO, pulse done, return to IDLE. A late ack after that point is ignored.
- RESP: single cycle with done=1, then IDLE.
- busy=1 in REQ and RESP. start while busy is ignored: no queuing, no state change.
- mem_ack while mem_req=0 is ignored.
- stat and val_m hold their last values until the next done.
- reset mid-operation: mem_req drops at that edge, done is not asserted, and the pending operation is discarded.
- The counter is cleared on entry to REQ. Its width is clog2(TIMEOUT+1).

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT, NOP, CMOV, IRMOV, RMMOV, MRMOV, OPQ, JXX, CALL, RET, PUSH, POP).
  - stat encoding (STAT_AOK, STAT_ADR, STAT_DMEM, STAT_TMO).
  - state enum.
- One natural sub-module, mem_op_decode: combinational icode/val_e/val_a/val_p → {access, we, addr, wdata, addr_ok}. The FSM, counter and output registers stay in the top.

Test Plan:
- Reset, then mrmovq (icode=5, val_e=100), responder acks 3 cycles after req with rdata=0x1234 → mem_req high for 3 cycles, mem_we=0, mem_addr=100, val_m=0x1234, stat=0, done one cycle after ack.
- pushq (icode=0xA, val_e=4095, val_a=-7) with immediate ack → mem_we=1, mem_wdata=0xFFFFFFFFFFFFFFF9, done at start+2, stat=0.
- rmmovq with val_e=4096 → no mem_req, done at start+1, stat=1 (ADR). Repeat with val_e=-1 (unsigned huge) → stat=1.
- call (icode=8, val_e=50, val_p=0x20), responder never acks, TIMEOUT=16 → mem_req high for exactly 16 cycles, then done with stat=3. A late ack 2 cycles after drop is ignored; busy=0.
- ret (icode=9, val_a=10) acked with mem_err=1 → stat=2. Follow with nop (icode=1) → done at start+1, stat=0, val_m unchanged.
- reset asserted mid-REQ with start pulsed again while busy → mem_req=0 after the reset edge, no done pulse, second start ignored; a fresh start after reset runs normally.
